apb_master_nslave: RTL and testbench
====================================

Name: apb_master_nslave

Overview:
Parametrised APB4 master bridge between the RV32I load/store port and N_SLV peripheral slaves (UART, timers, GPIO, ...). It replaces the fixed master plus single-slave decoder pair. It adds:
- internal multi-slave address decode
- per-slave PREADY/PSLVERR muxing
- an error response for unmapped addresses
- a programmable wait-state timeout, so a hung slave cannot stall the core.

Parameters:
WIDTH, 32, data and address width in bits.
N_SLV, 4, number of APB slaves (1..16); IDXW = max(1, clog2(N_SLV)).
BASE_ADDR, 32'h4000_0000, address of slave 0 window.
DEC_LSB, 12, log2 of window size; slave i occupies BASE_ADDR + i*2^DEC_LSB.
TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
CLK  in  1  system clock, all logic on rising edge.
RESET  in  1  asynchronous active-low reset.
req_valid  in  1  CPU request present.
req_write  in  1  1 = store, 0 = load.
req_addr  in  WIDTH  byte address.
req_wdata  in  WIDTH  store data.
req_strb  in  WIDTH/8  byte enables for stores.
req_ready  out  1  bridge can accept a request this cycle.
rsp_valid  out  1  one-cycle response pulse.
rsp_rdata  out  WIDTH  load data; 0 on writes and errors.
rsp_err  out  1  slave error, unmapped address or timeout.
PADDR  out  WIDTH  APB address.
PWDATA  out  WIDTH  APB write data.
PSTRB  out  WIDTH/8  APB strobes.
PWRITE  out  1  APB direction.
PENABLE  out  1  APB access phase.
PSEL  out  N_SLV  one-hot slave select.
PRDATA  in  N_SLV*WIDTH  concatenated slave read data; slave i occupies [i*WIDTH +: WIDTH].
PREADY  in  N_SLV  per-slave ready.
PSLVERR  in  N_SLV  per-slave error.

Behaviour:
- Reset (RESET low, asynchronous) values: state IDLE, and every output 0 except req_ready=1. Reset mid-transfer aborts silently: no rsp_valid, and PSEL/PENABLE drop immediately.
- States:
  - IDLE: req_ready=1.
  - SETUP: PSEL[idx]=1, PENABLE=0.
  - ACCESS: PSEL[idx]=1, PENABLE=1.
  - RESP: rsp_valid=1.
  - req_ready=0 in every state except IDLE.
- IDLE transition on req_valid: latch addr, wdata, strb, write and idx.
  - Mapped address: go to SETUP.
  - Unmapped address: go to RESP with rsp_err=1 and rdata=0. No APB activity.
- Decode:
  - off = req_addr - BASE_ADDR.
  - Mapped iff req_addr >= BASE_ADDR and off[WIDTH-1:DEC_LSB] < N_SLV.
  - idx = off[DEC_LSB +: IDXW].
- SETUP always goes to ACCESS after one cycle. Clear the wait counter on entry to ACCESS.
- ACCESS:
  - PREADY[idx]=1: capture PRDATA slice (loads only, else 0) and PSLVERR[idx] into rsp_err. Next cycle is RESP; PSEL/PENABLE go to 0.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: go to RESP with rsp_err=1 and rdata=0.
  - Else: increment the counter.
  - PREADY wins over timeout in the same cycle.
- RESP: rsp_valid high for exactly one cycle, then IDLE. rsp_rdata and rsp_err are held until the next response. The CPU cannot stall responses.
- Minimum latency: request accepted at cycle 0 gives SETUP at 1, ACCESS at 2, RESP at 3. Peak throughput is one transfer per 4 cycles.
- PADDR, PWDATA, PSTRB and PWRITE are registered from the latched request and stable from SETUP through the end of ACCESS.
- PSTRB is forced to 0 on reads.
- PREADY/PSLVERR/PRDATA of non-selected slaves are ignored.
- Only the latched idx is ever selected; PSEL is never multi-hot.
- Counter width = clog2(TIMEOUT+1); the counter never wraps.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, RESP)
  - the APB4 strobe-width function
  - the clog2 helper.
- Sub-module apb_slave_decoder: combinational addr -> {mapped, idx}, parametrised by BASE_ADDR, DEC_LSB, N_SLV. It is reused by the SoC top for debug visibility.
- The FSM, wait counter and mux stay in apb_master_nslave.

Test Plan:
1. Write to slave 0: addr 0x4000_0004, wdata 0xDEAD_BEEF, strb 4'hF, PREADY[0] high in ACCESS -> PSEL=0001 at cycle 1, PENABLE at cycle 2, rsp_valid at cycle 3 with err=0 and rdata=0.
2. Read from slave 2: addr 0x4000_2010, PRDATA[2]=0x1234_5678, PREADY[2] after 3 wait cycles -> PSTRB=0, rsp_valid at cycle 6, rdata=0x1234_5678; PSEL[2] only.
3. Unmapped addresses 0x4000_4000 and 0x3FFF_FFFC -> no PSEL, rsp_valid the cycle after acceptance, err=1, rdata=0.
4. Timeout with TIMEOUT=16 and PREADY held low -> abort after 16 ACCESS cycles, err=1. With PREADY asserted on cycle 16 exactly -> normal completion, err=0.
5. PSLVERR[1]=1 with PREADY on a write -> rsp_err=1.
6. Assert RESET low during ACCESS -> PSEL/PENABLE go low asynchronously, no rsp_valid. After release, the next request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constant helpers for the APB4 master bridge and its address decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // One PSTRB bit per data byte.
    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Combinational address decode: which slave window (if any) an address falls into.
module apb_slave_decoder
    import apb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_SLV = 4,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int DEC_LSB = 12,
    localparam int IDXW = (clog2(N_SLV) > 1) ? clog2(N_SLV) : 1
) (
    input  logic [WIDTH-1:0] addr,
    output logic             mapped,
    output logic [IDXW-1:0]  idx
);

    logic [WIDTH-1:0] off;
    logic [WIDTH-1:0] window;

    assign off    = addr - BASE_ADDR;
    assign window = off >> DEC_LSB;

    // The >= test rejects addresses below the base that wrap into a small offset.
    assign mapped = (addr >= BASE_ADDR) && (window < WIDTH'(N_SLV));
    assign idx    = window[IDXW-1:0];

endmodule

// File: rtl/apb_master_nslave.sv
// APB4 master bridge from the CPU load/store port to N_SLV slaves, with decode, error and timeout.
module apb_master_nslave
    import apb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_SLV = 4,
    parameter logic [WIDTH-1:0] BASE_ADDR = 32'h4000_0000,
    parameter int DEC_LSB = 12,
    parameter int TIMEOUT = 16,
    localparam int SW = strb_width(WIDTH),
    localparam int IDXW = (clog2(N_SLV) > 1) ? clog2(N_SLV) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [WIDTH-1:0]       req_addr,
    input  logic [WIDTH-1:0]       req_wdata,
    input  logic [SW-1:0]          req_strb,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       PADDR,
    output logic [WIDTH-1:0]       PWDATA,
    output logic [SW-1:0]          PSTRB,
    output logic                   PWRITE,
    output logic                   PENABLE,
    output logic [N_SLV-1:0]       PSEL,
    input  logic [N_SLV*WIDTH-1:0] PRDATA,
    input  logic [N_SLV-1:0]       PREADY,
    input  logic [N_SLV-1:0]       PSLVERR
);

    localparam int CNTW = (clog2(TIMEOUT + 1) > 1) ? clog2(TIMEOUT + 1) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT != 0);

    apb_state_t        state_reg, state_next;
    logic [WIDTH-1:0]  addr_reg, wdata_reg, rdata_reg;
    logic [SW-1:0]     strb_reg;
    logic              write_reg, err_reg;
    logic [IDXW-1:0]   idx_reg;
    logic [CNTW-1:0]   cnt_reg;

    logic              dec_mapped;
    logic [IDXW-1:0]   dec_idx;
    logic [N_SLV-1:0]  idx_hot;
    logic              sel_ready, sel_err, timed_out;
    logic [WIDTH-1:0]  sel_rdata;

    apb_slave_decoder #(
        .WIDTH    (WIDTH),
        .N_SLV    (N_SLV),
        .BASE_ADDR(BASE_ADDR),
        .DEC_LSB  (DEC_LSB)
    ) u_decoder (
        .addr  (req_addr),
        .mapped(dec_mapped),
        .idx   (dec_idx)
    );

    for (genvar gi = 0; gi < N_SLV; gi++) begin : g_hot
        assign idx_hot[gi] = (idx_reg == IDXW'(gi));
    end

    // Only the latched slave's handshake and data are ever looked at.
    assign sel_ready = |(PREADY & idx_hot);
    assign sel_err   = |(PSLVERR & idx_hot);
    assign timed_out = TO_EN && (cnt_reg == CNT_LAST);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (idx_hot[i]) begin
                sel_rdata = PRDATA[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (req_valid) state_next = dec_mapped ? SETUP : RESP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (sel_ready || timed_out) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_reg == IDLE);
        rsp_valid = (state_reg == RESP);
        PENABLE   = (state_reg == ACCESS);
        PSEL      = ((state_reg == SETUP) || (state_reg == ACCESS)) ? idx_hot : '0;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            strb_reg  <= '0;
            write_reg <= 1'b0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        strb_reg  <= req_write ? req_strb : '0;
                        write_reg <= req_write;
                        idx_reg   <= dec_idx;
                        if (!dec_mapped) begin
                            rdata_reg <= '0;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                SETUP: cnt_reg <= '0;
                ACCESS: begin
                    // A ready slave completes normally even on the last allowed cycle.
                    if (sel_ready) begin
                        rdata_reg <= write_reg ? '0 : sel_rdata;
                        err_reg   <= sel_err;
                    end else if (timed_out) begin
                        rdata_reg <= '0;
                        err_reg   <= 1'b1;
                    end else if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign PADDR     = addr_reg;
    assign PWDATA    = wdata_reg;
    assign PSTRB     = strb_reg;
    assign PWRITE    = write_reg;
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_apb_master_nslave.sv
// Self-checking bench: vector table of APB transfers, scoreboard on responses, plus a reset-abort sequence.
module tb_apb_master_nslave;

    localparam int W = 32;
    localparam int N = 4;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [W-1:0]  req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic [3:0]    req_strb = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_err;
    logic [W-1:0]  PADDR;
    logic [W-1:0]  PWDATA;
    logic [3:0]    PSTRB;
    logic          PWRITE;
    logic          PENABLE;
    logic [N-1:0]  PSEL;
    logic [N*W-1:0] PRDATA = '0;
    logic [N-1:0]  PREADY = '0;
    logic [N-1:0]  PSLVERR = '0;

    int n_checks = 0;
    int n_errors = 0;

    apb_master_nslave dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .req_valid(req_valid),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_strb (req_strb),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          slave;
        int          waits;      // ACCESS cycles before PREADY; -1 = never ready
        logic [31:0] prdata;
        logic        slverr;
        logic [3:0]  exp_psel;
        int          exp_lat;    // cycle of rsp_valid, acceptance = cycle 0
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb_q[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RESET && rsp_valid) begin
            chk("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                rsp_t e;
                e = sb_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic drive_slaves(input vec_t v, input logic in_access, input logic rdy);
        PREADY  = '0;
        PSLVERR = '0;
        PRDATA  = '0;
        if (in_access) begin
            for (int i = 0; i < N; i++) begin
                if (i == v.slave) begin
                    PREADY[i]         = rdy;
                    PSLVERR[i]        = rdy & v.slverr;
                    PRDATA[i*W +: W]  = v.prdata;
                end else begin
                    PREADY[i]         = 1'b1;
                    PSLVERR[i]        = 1'b1;
                    PRDATA[i*W +: W]  = $urandom;
                end
            end
        end
    endtask

    task automatic run_txn(input int id, input vec_t v);
        int   acc_k;
        bit   done;
        int   lat;
        rsp_t e;
        @(negedge CLK);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        acc_k = 0;
        done  = 0;
        lat   = -1;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge CLK);
            drive_slaves(v, 1'b0, 1'b0);
            if (rsp_valid) begin
                chk("latency", 32'(cyc), 32'(v.exp_lat));
                chk("psel_in_resp", 32'(PSEL), 32'd0);
                chk("req_ready_busy", 32'(req_ready), 32'd0);
                lat  = cyc;
                done = 1;
            end else if (PENABLE) begin
                chk("psel_access", 32'(PSEL), 32'(v.exp_psel));
                chk("paddr", PADDR, v.addr);
                chk("pwrite", 32'(PWRITE), 32'(v.write));
                chk("pstrb", 32'(PSTRB), v.write ? 32'(v.strb) : 32'd0);
                if (v.write) chk("pwdata", PWDATA, v.wdata);
                drive_slaves(v, 1'b1, (v.waits >= 0) && (acc_k == v.waits));
                acc_k++;
            end else begin
                chk("setup_cycle", 32'(cyc), 32'd1);
                chk("psel_setup", 32'(PSEL), 32'(v.exp_psel));
                chk("paddr_setup", PADDR, v.addr);
            end
        end
        if (!done) chk("rsp_timeout_bound", 32'd0, 32'd1);
        @(negedge CLK);
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("rsp_rdata_held", rsp_rdata, v.exp_rdata);
        $display("txn %0d %s addr=%h lat=%0d err=%0b rdata=%h", id, v.write ? "WR" : "RD",
                 v.addr, lat, rsp_err, rsp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        //          wr    addr           wdata          strb  slv wait prdata         err  psel    lat err rdata
        vecs[0] = '{1'b1, 32'h4000_0004, 32'hDEAD_BEEF, 4'hF, 0,  0,  32'h1111_1111, 1'b0, 4'b0001, 3,  1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h4000_2010, 32'h0,         4'hF, 2,  3,  32'h1234_5678, 1'b0, 4'b0100, 6,  1'b0, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h4000_4000, 32'h5555_AAAA, 4'hF, 0,  0,  32'h0,         1'b0, 4'b0000, 1,  1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h3FFF_FFFC, 32'h0,         4'h0, 0,  0,  32'h0,         1'b0, 4'b0000, 1,  1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'h4000_1008, 32'hCAFE_F00D, 4'h3, 1,  0,  32'h0,         1'b1, 4'b0010, 3,  1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h4000_3FFC, 32'h0,         4'hC, 3,  1,  32'hA5A5_0001, 1'b0, 4'b1000, 4,  1'b0, 32'hA5A5_0001};
        vecs[6] = '{1'b0, 32'h4000_1000, 32'h0,         4'h0, 1,  -1, 32'h7777_7777, 1'b0, 4'b0010, 18, 1'b1, 32'h0};
        vecs[7] = '{1'b0, 32'h4000_0000, 32'h0,         4'h0, 0,  15, 32'h0BAD_C0DE, 1'b0, 4'b0001, 18, 1'b0, 32'h0BAD_C0DE};
        vecs[8] = '{1'b1, 32'h4000_2FF0, 32'h0102_0304, 4'h9, 2,  -1, 32'h0,         1'b0, 4'b0100, 18, 1'b1, 32'h0};

        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_paddr", PADDR, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        RESET = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_txn(i, vecs[i]);
        end

        // Reset asserted mid-ACCESS aborts without a response
        rv = '{1'b0, 32'h4000_1004, 32'h0, 4'h0, 1, -1, 32'h3333_3333, 1'b0, 4'b0010, 0, 1'b0, 32'h0};
        @(negedge CLK);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = rv.addr;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        @(negedge CLK);
        chk("abort_setup_psel", 32'(PSEL), 32'b0010);
        @(negedge CLK);
        chk("abort_access_penable", 32'(PENABLE), 32'd1);
        drive_slaves(rv, 1'b1, 1'b0);
        #2;
        RESET = 1'b0;
        #1;
        chk("abort_psel_async", 32'(PSEL), 32'd0);
        chk("abort_penable_async", 32'(PENABLE), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        drive_slaves(rv, 1'b0, 1'b0);
        repeat (2) @(negedge CLK);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        RESET = 1'b1;
        $display("txn abort RD addr=%h reset during ACCESS", rv.addr);

        run_txn(9, vecs[5]);
        run_txn(10, vecs[0]);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
